// File: rtl/instr_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
// The optional halt-on-0xFF behaviour is enabled with INSTR_FETCH_HALT_DETECT_EN.
package instr_fetch_pkg;

  localparam int AW     = 4;
  localparam int DW     = 8;
  localparam int QDEPTH = 2;

  localparam logic [DW-1:0] HALT_WORD = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO that holds fetched {pc, word} pairs for the decoder.
// Entry 0 is always the head, so the head output is a plain register.
module fetch_queue
  import instr_fetch_pkg::*;
#(
  parameter int W = AW + DW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  localparam logic [1:0] FULL = 2'(QDEPTH);

  logic [W-1:0] entry0;
  logic [W-1:0] entry1;
  logic [1:0]   cnt;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop && (cnt != 2'd0);
  assign push_ok = push && ((cnt != FULL) || pop_ok);

  // Flush wins over push and pop; a simultaneous pop is simply absorbed by it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0 <= '0;
      entry1 <= '0;
      cnt    <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) entry0 <= din;
          else             entry1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          cnt    <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            entry0 <= din;
          end else begin
            entry0 <= entry1;
            entry1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = entry0;
  assign count = cnt;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads the ROM and queues words for the decoder.
// Define INSTR_FETCH_HALT_DETECT_EN to stop fetching after a fetched 0xFF word.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] address,
  input  logic [DW-1:0] r_bus,
  output logic [DW-1:0] instr_out,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  output logic          busy,
  output logic          halted
);

  state_t          state;
  state_t          next_state;
  logic [AW-1:0]   pc;
  logic [AW-1:0]   pc_next;
  logic            push;
  logic            flush;
  logic            pop;
  logic            can_push;
  logic [1:0]      count;
  logic [AW+DW-1:0] head;

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid & instr_ready;
  assign can_push    = (count != 2'(QDEPTH)) || pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Redirect overrides everything; start only matters while not fetching.
  always_comb begin
    next_state = state;
    if (redirect) begin
      next_state = FETCH;
    end else begin
      case (state)
        IDLE:  if (start) next_state = FETCH;
        FETCH: begin
`ifdef INSTR_FETCH_HALT_DETECT_EN
          if (can_push && (r_bus == HALT_WORD)) next_state = HALT;
`endif
        end
        HALT:  if (start) next_state = FETCH;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    push    = 1'b0;
    flush   = 1'b0;
    pc_next = pc;
    if (redirect) begin
      flush   = 1'b1;
      pc_next = redirect_addr;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            flush   = 1'b1;
            pc_next = '0;
          end
        end
        FETCH: begin
          if (can_push) begin
            push    = 1'b1;
            pc_next = pc + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else        pc <= pc_next;
  end

  fetch_queue #(.W(AW + DW)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({pc, r_bus}),
    .pop   (pop),
    .flush (flush),
    .head  (head),
    .count (count)
  );

  assign address   = pc;
  assign instr_out = head[DW-1:0];
  assign instr_pc  = head[AW+DW-1:DW];
  assign busy      = (state == FETCH);

`ifdef INSTR_FETCH_HALT_DETECT_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_instr_fetch;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] address;
  logic [7:0] r_bus;
  logic [7:0] instr_out;
  logic [3:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       redirect;
  logic [3:0] redirect_addr;
  logic       busy;
  logic       halted;

  logic [7:0] rom [16];

  int n_cmp;
  int n_fail;

  instr_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .address       (address),
    .r_bus         (r_bus),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .busy          (busy),
    .halted        (halted)
  );

  assign r_bus = rom[address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the fetch unit as "a PC, a mode and a list of pending words".
  typedef enum {M_IDLE, M_RUN, M_HALTED} mode_t;
  mode_t       m_mode;
  int          m_pc;
  logic [11:0] m_q[$];

  function automatic void modelReset();
    m_mode = M_IDLE;
    m_pc   = 0;
    m_q.delete();
  endfunction

  function automatic void modelStep(logic s, logic r, logic rd, logic [3:0] ra);
    logic [7:0] w;
    if (rd) begin
      m_q.delete();
      m_pc   = int'(ra);
      m_mode = M_RUN;
    end else if (m_mode != M_RUN && s) begin
      m_q.delete();
      m_pc   = 0;
      m_mode = M_RUN;
    end else begin
      if (r && m_q.size() > 0) void'(m_q.pop_front());
      if (m_mode == M_RUN && m_q.size() < 2) begin
        w = rom[m_pc];
        m_q.push_back({4'(m_pc), w});
`ifdef INSTR_FETCH_HALT_DETECT_EN
        if (w == 8'hFF) m_mode = M_HALTED;
`endif
        m_pc = (m_pc + 1) % 16;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, take one rising edge, settle at the next falling edge.
  task automatic applyStimulus(input logic s, input logic r, input logic rd, input logic [3:0] ra);
    start         = s;
    instr_ready   = r;
    redirect      = rd;
    redirect_addr = ra;
    @(posedge clk);
    modelStep(s, r, rd, ra);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n         = 1'b0;
    start         = 1'b0;
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 4'd0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expectState(input string tag, input logic v, input logic [7:0] o, input logic [3:0] p,
                             input logic [3:0] a, input logic b, input logic h);
    checkOutput({tag, "_valid"}, int'(instr_valid), int'(v));
    checkOutput({tag, "_addr"}, int'(address), int'(a));
    checkOutput({tag, "_busy"}, int'(busy), int'(b));
    checkOutput({tag, "_halted"}, int'(halted), int'(h));
    if (v) begin
      checkOutput({tag, "_out"}, int'(instr_out), int'(o));
      checkOutput({tag, "_pc"}, int'(instr_pc), int'(p));
    end
  endtask

  task automatic compareModel(input string tag);
    logic mv;
    mv = (m_q.size() > 0);
    checkOutput({tag, "_valid"}, int'(instr_valid), int'(mv));
    checkOutput({tag, "_addr"}, int'(address), m_pc);
    checkOutput({tag, "_busy"}, int'(busy), int'(m_mode == M_RUN));
    checkOutput({tag, "_halted"}, int'(halted), int'(m_mode == M_HALTED));
    if (mv) begin
      checkOutput({tag, "_out"}, int'(instr_out), int'(m_q[0][7:0]));
      checkOutput({tag, "_pc"}, int'(instr_pc), int'(m_q[0][11:8]));
    end
  endtask

  typedef struct {
    logic       rst;
    logic       start;
    logic       ready;
    logic       redir;
    logic [3:0] raddr;
    logic       exp_valid;
    logic [7:0] exp_out;
    logic [3:0] exp_pc;
    logic [3:0] exp_addr;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rom = '{8'h91, 8'h12, 8'h23, 8'h34, 8'h86, 8'h45, 8'h56, 8'h67,
            8'h78, 8'hAB, 8'h09, 8'h0B, 8'h0C, 8'hFF, 8'h12, 8'h01};
    n_cmp  = 0;
    n_fail = 0;

    rst_n         = 1'b0;
    start         = 1'b0;
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 4'd0;
    modelReset();
    #1;
    checkOutput("reset_addr", int'(address), 0);
    checkOutput("reset_valid", int'(instr_valid), 0);
    checkOutput("reset_out", int'(instr_out), 0);
    checkOutput("reset_pc", int'(instr_pc), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_halted", int'(halted), 0);

    // Streaming from start, then a redirect to 10 on the same edge that pc3 is accepted.
    vecs.push_back(vec_t'{1, 1, 1, 0, 4'd0,  0, 8'h00, 4'd0,  4'd0,  1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 4'd0,  1, 8'h91, 4'd0,  4'd1,  1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 4'd0,  1, 8'h12, 4'd1,  4'd2,  1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 4'd0,  1, 8'h23, 4'd2,  4'd3,  1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 4'd0,  1, 8'h34, 4'd3,  4'd4,  1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 4'd0,  1, 8'h86, 4'd4,  4'd5,  1});
    vecs.push_back(vec_t'{1, 1, 1, 0, 4'd0,  0, 8'h00, 4'd0,  4'd0,  1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 4'd0,  1, 8'h91, 4'd0,  4'd1,  1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 4'd0,  1, 8'h12, 4'd1,  4'd2,  1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 4'd0,  1, 8'h23, 4'd2,  4'd3,  1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 4'd0,  1, 8'h34, 4'd3,  4'd4,  1});
    vecs.push_back(vec_t'{0, 0, 1, 1, 4'd10, 0, 8'h00, 4'd0,  4'd10, 1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 4'd0,  1, 8'h09, 4'd10, 4'd11, 1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 4'd0,  1, 8'h0B, 4'd11, 4'd12, 1});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) doReset();
      applyStimulus(vecs[i].start, vecs[i].ready, vecs[i].redir, vecs[i].raddr);
      expectState($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_out,
                  vecs[i].exp_pc, vecs[i].exp_addr, vecs[i].exp_busy, 1'b0);
    end

    // Backpressure: queue fills with pc0/pc1, PC parks at 2, then drains in order.
    doReset();
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0);
    expectState("bp_full", 1, 8'h91, 4'd0, 4'd2, 1, 0);
    applyStimulus(0, 1, 0, 0);
    expectState("bp_drain1", 1, 8'h12, 4'd1, 4'd3, 1, 0);
    applyStimulus(0, 1, 0, 0);
    expectState("bp_drain2", 1, 8'h23, 4'd2, 4'd4, 1, 0);

    // Asynchronous reset with two entries queued clears the queue without a clock edge.
    doReset();
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
    expectState("ar_pre", 1, 8'h91, 4'd0, 4'd2, 1, 0);
    rst_n = 1'b0;
    modelReset();
    #1;
    expectState("ar_async", 0, 8'h00, 4'd0, 4'd0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    expectState("ar_idle", 0, 8'h00, 4'd0, 4'd0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    expectState("ar_restart", 1, 8'h91, 4'd0, 4'd1, 1, 0);

    // 0xFF at pc13: halts when detection is built in, otherwise fetching wraps.
    doReset();
    applyStimulus(0, 1, 1, 4'd12);
    expectState("hw_redir", 0, 8'h00, 4'd0, 4'd12, 1, 0);
    applyStimulus(0, 1, 0, 0);
    expectState("hw_pc12", 1, 8'h0C, 4'd12, 4'd13, 1, 0);
`ifdef INSTR_FETCH_HALT_DETECT_EN
    applyStimulus(0, 1, 0, 0);
    expectState("hw_pc13", 1, 8'hFF, 4'd13, 4'd14, 0, 1);
    applyStimulus(0, 1, 0, 0);
    expectState("hw_drained", 0, 8'h00, 4'd0, 4'd14, 0, 1);
    applyStimulus(0, 1, 0, 0);
    expectState("hw_frozen", 0, 8'h00, 4'd0, 4'd14, 0, 1);
    applyStimulus(1, 1, 0, 0);
    expectState("hw_restart", 0, 8'h00, 4'd0, 4'd0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    expectState("hw_pc0", 1, 8'h91, 4'd0, 4'd1, 1, 0);
`else
    applyStimulus(0, 1, 0, 0);
    expectState("hw_pc13", 1, 8'hFF, 4'd13, 4'd14, 1, 0);
    applyStimulus(0, 1, 0, 0);
    expectState("hw_pc14", 1, 8'h12, 4'd14, 4'd15, 1, 0);
    applyStimulus(0, 1, 0, 0);
    expectState("hw_pc15", 1, 8'h01, 4'd15, 4'd0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    expectState("hw_wrap", 1, 8'h91, 4'd0, 4'd1, 1, 0);
`endif

    // Randomized traffic against the reference model.
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
      compareModel($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
